// File: rtl/irs_wilkinson_monitor_multi.sv
// Multi-channel Wilkinson TSTOUT period monitor: per-channel 2^L-edge windows timed in clk_i cycles.
// Optional stuck-channel timeout is compiled in with `define WILKINSON_MON_TIMEOUT_EN.
module irs_wilkinson_monitor_multi #(
  parameter int NCH      = 4,
  parameter int CNT_W    = 16,
  parameter int MAX_LOG2 = 10
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [NCH-1:0]   tstout_i,
  input  logic [3:0]       log2_edges_i,
  input  logic [3:0]       sel_i,
  input  logic             rd_i,
  output logic [CNT_W-1:0] count_o,
  output logic             sat_o,
  output logic [NCH-1:0]   new_o,
  output logic [NCH-1:0]   stuck_o
);

  localparam logic [CNT_W-1:0]    CNT_ONES = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]    CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [MAX_LOG2-1:0] ECNT_ONE = {{(MAX_LOG2-1){1'b0}}, 1'b1};

  logic [NCH-1:0]      sync1_q, sync2_q, sync3_q, pulse_q;
  logic [3:0]          log2_q;
  logic [MAX_LOG2-1:0] ecnt_q [NCH];
  logic [MAX_LOG2-1:0] ecnt_d [NCH];
  logic [CNT_W-1:0]    ccnt_q [NCH];
  logic [CNT_W-1:0]    ccnt_d [NCH];
  logic [CNT_W-1:0]    lat_q  [NCH];
  logic [CNT_W-1:0]    lat_d  [NCH];
  logic [NCH-1:0]      lsat_q, lsat_d, armed_q, armed_d, new_q, new_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                sat_q, sat_d;
  logic                restart_s;
  logic [MAX_LOG2-1:0] last_s;

  assign restart_s = (log2_edges_i != log2_q);

  // Edge-counter terminal value 2^L-1; bits above MAX_LOG2 do not exist, which clamps L.
  always_comb begin
    last_s = {MAX_LOG2{1'b0}};
    for (int b = 0; b < MAX_LOG2; b++) begin
      last_s[b] = (int'(log2_q) > b) ? 1'b1 : 1'b0;
    end
  end

  // Per-channel window, cycle-count and latch next state; a latch set beats a read clear.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      new_d[c]   = (rd_i && (sel_i == 4'(c))) ? 1'b0 : new_q[c];
      ecnt_d[c]  = ecnt_q[c];
      ccnt_d[c]  = ccnt_q[c];
      lat_d[c]   = lat_q[c];
      lsat_d[c]  = lsat_q[c];
      armed_d[c] = armed_q[c];
      if (restart_s) begin
        ecnt_d[c]  = {MAX_LOG2{1'b0}};
        ccnt_d[c]  = {CNT_W{1'b0}};
        armed_d[c] = 1'b0;
      end else if (pulse_q[c] && (ecnt_q[c] == last_s)) begin
        ecnt_d[c]  = {MAX_LOG2{1'b0}};
        ccnt_d[c]  = CNT_ONE;
        armed_d[c] = 1'b1;
        if (armed_q[c]) begin
          lat_d[c]  = ccnt_q[c];
          lsat_d[c] = (ccnt_q[c] == CNT_ONES);
          new_d[c]  = 1'b1;
        end else begin
          lat_d[c]  = lat_q[c];
          lsat_d[c] = lsat_q[c];
        end
      end else begin
        ecnt_d[c] = pulse_q[c] ? (ecnt_q[c] + ECNT_ONE) : ecnt_q[c];
        ccnt_d[c] = (ccnt_q[c] == CNT_ONES) ? ccnt_q[c] : (ccnt_q[c] + CNT_ONE);
      end
    end
  end

  // Readout mux; out-of-range selects fall through to zero.
  always_comb begin
    count_d = {CNT_W{1'b0}};
    sat_d   = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      count_d = (sel_i == 4'(c)) ? lat_q[c]  : count_d;
      sat_d   = (sel_i == 4'(c)) ? lsat_q[c] : sat_d;
    end
  end

  // State registers, including synchronizer chain and registered edge pulse.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= {NCH{1'b0}};
      sync2_q <= {NCH{1'b0}};
      sync3_q <= {NCH{1'b0}};
      pulse_q <= {NCH{1'b0}};
      log2_q  <= 4'd0;
      lsat_q  <= {NCH{1'b0}};
      armed_q <= {NCH{1'b0}};
      new_q   <= {NCH{1'b0}};
      count_q <= {CNT_W{1'b0}};
      sat_q   <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        ecnt_q[c] <= {MAX_LOG2{1'b0}};
        ccnt_q[c] <= {CNT_W{1'b0}};
        lat_q[c]  <= {CNT_W{1'b0}};
      end
    end else begin
      sync1_q <= tstout_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      pulse_q <= sync2_q & ~sync3_q;
      log2_q  <= log2_edges_i;
      lsat_q  <= lsat_d;
      armed_q <= armed_d;
      new_q   <= new_d;
      count_q <= count_d;
      sat_q   <= sat_d;
      for (int c = 0; c < NCH; c++) begin
        ecnt_q[c] <= ecnt_d[c];
        ccnt_q[c] <= ccnt_d[c];
        lat_q[c]  <= lat_d[c];
      end
    end
  end

`ifdef WILKINSON_MON_TIMEOUT_EN
  logic [NCH-1:0] stuck_q, stuck_d;

  // Flag a channel whose cycle counter just hit all-ones; its next edge clears it.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      if (pulse_q[c]) begin
        stuck_d[c] = 1'b0;
      end else if ((ccnt_d[c] == CNT_ONES) && (ccnt_q[c] != CNT_ONES)) begin
        stuck_d[c] = 1'b1;
      end else begin
        stuck_d[c] = stuck_q[c];
      end
    end
  end

  // Timeout flag register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stuck_q <= {NCH{1'b0}};
    end else begin
      stuck_q <= stuck_d;
    end
  end

  assign stuck_o = stuck_q;
`else
  assign stuck_o = {NCH{1'b0}};
`endif

  assign count_o = count_q;
  assign sat_o   = sat_q;
  assign new_o   = new_q;

endmodule

// File: tb/tb_irs_wilkinson_monitor_multi.sv
// Bench for irs_wilkinson_monitor_multi: window-level timestamp model versus the DUT, cycle by cycle.
module tb_irs_wilkinson_monitor_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  tstout;
  logic [3:0]  log2_e;
  logic [3:0]  sel;
  logic        rd;
  logic [15:0] count;
  logic        sat;
  logic [3:0]  newf;
  logic [3:0]  stuck;

  always #5 clk = ~clk;

  irs_wilkinson_monitor_multi #(.NCH(4), .CNT_W(16), .MAX_LOG2(10)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .tstout_i(tstout), .log2_edges_i(log2_e),
    .sel_i(sel), .rd_i(rd), .count_o(count), .sat_o(sat), .new_o(newf), .stuck_o(stuck)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // stimulus generators: rise every per[c] clocks, high for two clocks
  int per[4], nxt[4], hi[4], rises[4], pend[4];
  bit gen_en[4];

  // reference model: time stamps of window ends, clamped differences
  int m_edges[4], m_base[4], m_lat[4], m_pulses[4], m_latches[4];
  bit m_armed[4], m_sat[4], m_new[4], m_stuck[4];
  int m_count, m_log2;
  bit m_sato;

  function automatic void model_reset();
    for (int c = 0; c < 4; c++) begin
      m_edges[c] = 0; m_base[c] = 0; m_lat[c] = 0; m_pulses[c] = 0; m_latches[c] = 0;
      m_armed[c] = 1'b0; m_sat[c] = 1'b0; m_new[c] = 1'b0; m_stuck[c] = 1'b0; pend[c] = -1;
    end
    m_count = 0; m_sato = 1'b0; m_log2 = 0;
  endfunction

  function automatic logic [3:0] exp_new();
    logic [3:0] r;
    for (int c = 0; c < 4; c++) r[c] = m_new[c];
    return r;
  endfunction

  function automatic logic [3:0] exp_stuck();
    logic [3:0] r;
    r = 4'b0000;
`ifdef WILKINSON_MON_TIMEOUT_EN
    for (int c = 0; c < 4; c++) r[c] = m_stuck[c];
`endif
    return r;
  endfunction

  task automatic step();
    int p, lc;
    bit rs, pulse, wend;
    for (int c = 0; c < 4; c++) begin
      if (gen_en[c]) begin
        if (nxt[c] == 0) begin
          tstout[c] = 1'b1; hi[c] = 1; nxt[c] = per[c] - 1; rises[c]++; pend[c] = cyc + 4;
        end else begin
          nxt[c]--;
          if (hi[c] > 0) hi[c]--; else tstout[c] = 1'b0;
        end
      end
    end
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      p = cyc;
      m_count = (sel < 4'd4) ? m_lat[int'(sel)] : 0;
      m_sato  = (sel < 4'd4) ? m_sat[int'(sel)] : 1'b0;
      rs = (int'(log2_e) != m_log2);
      lc = (m_log2 > 10) ? 10 : m_log2;
      m_log2 = int'(log2_e);
      if (rd && sel < 4'd4) m_new[int'(sel)] = 1'b0;
      for (int c = 0; c < 4; c++) begin
        pulse = (pend[c] == p);
        if (pulse) begin pend[c] = -1; m_pulses[c]++; end
        if (rs) begin
          m_edges[c] = 0; m_armed[c] = 1'b0; m_base[c] = p;
        end else begin
          wend = pulse && (m_edges[c] + 1 == (1 << lc));
          if (!wend && (p - m_base[c] == 65535)) m_stuck[c] = 1'b1;
          if (pulse) begin m_stuck[c] = 1'b0; m_edges[c]++; end
          if (wend) begin
            m_edges[c] = 0;
            if (m_armed[c]) begin
              m_lat[c] = (p - 1 - m_base[c] > 65535) ? 65535 : (p - 1 - m_base[c]);
              m_sat[c] = (m_lat[c] == 65535);
              m_new[c] = 1'b1;
              m_latches[c]++;
            end
            m_armed[c] = 1'b1;
            m_base[c] = p - 1;
          end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (count !== 16'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_checks++; if (sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat got=%b exp=0", sat); end
    n_checks++; if (newf !== 4'd0) begin n_fail++; $display("FAIL reset_new got=%b exp=0000", newf); end
    n_checks++; if (stuck !== 4'd0) begin n_fail++; $display("FAIL reset_stuck got=%b exp=0000", stuck); end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++; if (newf !== exp_new()) begin n_fail++; $display("FAIL post_reset_new cyc=%0d got=%b exp=%b", cyc, newf, exp_new()); end
      n_checks++; if (count !== 16'(m_count)) begin n_fail++; $display("FAIL post_reset_count cyc=%0d got=%0d exp=%0d", cyc, count, m_count); end
    end
  endtask

  task automatic test_basic_sat();
    bit ch0_seen = 1'b0, ch0_done = 1'b0, ch1_done = 1'b0;
    per = '{312, 20, int'($urandom_range(150, 600)), int'($urandom_range(150, 600))};
    nxt = '{5, 7, 11, 13};
    for (int c = 0; c < 4; c++) gen_en[c] = 1'b1;
    for (int i = 0; i < 72000; i++) begin
      if (rises[1] == 126) per[1] = 64400; else if (rises[1] >= 127) per[1] = 20;
      rd = 1'b0; sel = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 63) == 0) begin rd = 1'b1; sel = 4'($urandom_range(2, 15)); end
      if (rises[0] >= 141 && !ch0_done) begin rd = 1'b0; sel = 4'd0; end
      else if (m_latches[1] >= 1 && !ch1_done) begin rd = 1'b0; sel = 4'd1; end
      step();
      n_checks++; if (newf !== exp_new()) begin n_fail++; $display("FAIL basic_new cyc=%0d got=%b exp=%b", cyc, newf, exp_new()); end
      n_checks++; if (count !== 16'(m_count)) begin n_fail++; $display("FAIL basic_count cyc=%0d got=%0d exp=%0d", cyc, count, m_count); end
      n_checks++; if (sat !== m_sato) begin n_fail++; $display("FAIL basic_sat cyc=%0d got=%b exp=%b", cyc, sat, m_sato); end
      n_checks++; if (stuck !== exp_stuck()) begin n_fail++; $display("FAIL basic_stuck cyc=%0d got=%b exp=%b", cyc, stuck, exp_stuck()); end
      if (newf[0] && !ch0_seen) begin
        ch0_seen = 1'b1;
        n_checks++; if (m_pulses[0] != 128) begin n_fail++; $display("FAIL ch0_first_latch_edge got=%0d exp=128", m_pulses[0]); end
      end
      if (sel == 4'd0 && !rd && rises[0] >= 141 && !ch0_done) begin
        ch0_done = 1'b1;
        n_checks++; if (count !== 16'd19968 || sat !== 1'b0 || newf[0] !== 1'b1) begin
          n_fail++; $display("FAIL ch0_read got=%0d/%b/%b exp=19968/0/1", count, sat, newf[0]);
        end
      end else if (sel == 4'd1 && !rd && m_latches[1] >= 1 && !ch1_done) begin
        ch1_done = 1'b1;
        n_checks++; if (count !== 16'd65535 || sat !== 1'b1) begin
          n_fail++; $display("FAIL ch1_sat_read got=%0d/%b exp=65535/1", count, sat);
        end
      end
      if (ch0_done && ch1_done) break;
    end
    n_checks++; if (!(ch0_done && ch1_done)) begin n_fail++; $display("FAIL basic_timeout got=%b%b exp=11", ch0_done, ch1_done); end
  endtask

  task automatic test_restart();
    int p0, l0;
    bit found = 1'b0, done = 1'b0;
    rd = 1'b0; sel = 4'd0;
    for (int i = 0; i < 2000 && !found; i++) begin
      step();
      found = (m_edges[0] >= 1) && (pend[0] == -1);
    end
    log2_e = 4'd2; p0 = m_pulses[0]; l0 = m_latches[0];
    for (int i = 0; i < 6000 && found; i++) begin
      step();
      n_checks++; if (newf !== exp_new()) begin n_fail++; $display("FAIL restart_new cyc=%0d got=%b exp=%b", cyc, newf, exp_new()); end
      n_checks++; if (count !== 16'(m_count)) begin n_fail++; $display("FAIL restart_count cyc=%0d got=%0d exp=%0d", cyc, count, m_count); end
      if (m_latches[0] == l0) begin
        n_checks++; if (count !== 16'd19968) begin n_fail++; $display("FAIL restart_hold got=%0d exp=19968", count); end
      end else begin
        n_checks++; if (m_pulses[0] - p0 != 8) begin n_fail++; $display("FAIL restart_edges got=%0d exp=8", m_pulses[0] - p0); end
        step();
        n_checks++; if (count !== 16'd1248) begin n_fail++; $display("FAIL restart_value got=%0d exp=1248", count); end
        done = 1'b1;
        break;
      end
    end
    n_checks++; if (!done) begin n_fail++; $display("FAIL restart_timeout got=0 exp=1"); end
  endtask

  task automatic test_collision();
    bit done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rd = 1'b0; sel = 4'd0;
      if (pend[0] == cyc + 1 && m_armed[0] && m_edges[0] == 3) begin
        rd = 1'b1;
        step();
        n_checks++; if (newf[0] !== 1'b1) begin n_fail++; $display("FAIL collide_set_wins got=%b exp=1", newf[0]); end
        step();
        n_checks++; if (newf[0] !== 1'b0) begin n_fail++; $display("FAIL collide_next_clear got=%b exp=0", newf[0]); end
        rd = 1'b0;
        done = 1'b1;
        break;
      end
      step();
      n_checks++; if (newf !== exp_new()) begin n_fail++; $display("FAIL collide_new cyc=%0d got=%b exp=%b", cyc, newf, exp_new()); end
    end
    n_checks++; if (!done) begin n_fail++; $display("FAIL collide_timeout got=0 exp=1"); end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0, done = 1'b0;
    rd = 1'b0; sel = 4'd0;
    for (int i = 0; i < 3000 && !found; i++) begin
      step();
      found = (m_edges[0] == 2) && (tstout == 4'd0);
      for (int c = 0; c < 4; c++) found = found && (pend[c] == -1) && (nxt[c] > 6) && (hi[c] == 0);
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL reset_mid_window got=0 exp=1"); end
    rst_n = 1'b0;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      #1;
      n_checks++; if (count !== 16'd0 || sat !== 1'b0 || newf !== 4'd0 || stuck !== 4'd0) begin
        n_fail++; $display("FAIL reset_mid_zero got=%0d/%b/%b/%b exp=0/0/0000/0000", count, sat, newf, stuck);
      end
      if (k == 0) step();
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      step();
      n_checks++; if (newf !== exp_new()) begin n_fail++; $display("FAIL rmid_new cyc=%0d got=%b exp=%b", cyc, newf, exp_new()); end
      if (m_latches[0] == 1) begin
        n_checks++; if (m_pulses[0] != 8) begin n_fail++; $display("FAIL rmid_edges got=%0d exp=8", m_pulses[0]); end
        step();
        n_checks++; if (count !== 16'd1248) begin n_fail++; $display("FAIL rmid_value got=%0d exp=1248", count); end
        sel = 4'd7;
        step();
        n_checks++; if (count !== 16'd0 || sat !== 1'b0) begin n_fail++; $display("FAIL sel7_zero got=%0d/%b exp=0/0", count, sat); end
        done = 1'b1;
        break;
      end
    end
    n_checks++; if (!done) begin n_fail++; $display("FAIL rmid_timeout got=0 exp=1"); end
  endtask

  initial begin
    rst_n = 1'b0; tstout = 4'd0; log2_e = 4'd6; sel = 4'd0; rd = 1'b0;
    for (int c = 0; c < 4; c++) begin
      per[c] = 100; nxt[c] = 0; hi[c] = 0; rises[c] = 0; gen_en[c] = 1'b0;
    end
    test_reset();
    test_basic_sat();
    test_restart();
    test_collision();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
